// File: rtl/dot_product_engine.sv
// Sequential signed fixed-point dot product: one shared multiplier, one element per cycle, saturated result.
// Define DOTP_ROUND_EN to round half toward +inf before saturation; otherwise the result is truncated toward -inf.
module dot_product_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int EXT_DIM    = 4,
  parameter int FRAC_BITS  = 12
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic [0:DATA_WIDTH*EXT_DIM-1]       vector_a,
  input  logic [0:DATA_WIDTH*EXT_DIM-1]       vector_b,
  output logic                                done,
  output logic signed [DATA_WIDTH-1:0]        result
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(EXT_DIM) + 1;
  localparam int IDX_W = (EXT_DIM > 1) ? $clog2(EXT_DIM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXT_DIM - 1);

  typedef enum logic [1:0] {IDLE, MAC, NORM, HOLD} state_t;

  state_t                        state, state_nxt;
  logic signed [DATA_WIDTH-1:0]  a_q [EXT_DIM];
  logic signed [DATA_WIDTH-1:0]  b_q [EXT_DIM];
  logic signed [ACC_W-1:0]       acc;
  logic [IDX_W-1:0]              idx;
  logic signed [2*DATA_WIDTH-1:0] prod;

`ifdef DOTP_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'((1 << FRAC_BITS) >> 1);
`endif

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] x);
`ifdef DOTP_ROUND_EN
    round_shift = (x + RND) >>> FRAC_BITS;
`else
    round_shift = x >>> FRAC_BITS;
`endif
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] hi, lo;
    hi = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    lo = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    if (x > hi)      saturate = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (x < lo) saturate = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else             saturate = x[DATA_WIDTH-1:0];
  endfunction

  assign prod = a_q[idx] * b_q[idx];
  assign done = (state == HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = MAC;
      MAC: begin
        if (!start)               state_nxt = IDLE;
        else if (idx == IDX_LAST) state_nxt = NORM;
      end
      NORM:    state_nxt = start ? HOLD : IDLE;
      HOLD:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operands are only ever sampled on the IDLE capture edge; no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < EXT_DIM; i++) begin
        a_q[i] <= vector_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_q[i] <= vector_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          if (start) begin
            acc <= acc + ACC_W'(prod);
            idx <= idx + IDX_W'(1);
          end
        end
        NORM: if (start) result <= saturate(round_shift(acc));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed-vector bench for dot_product_engine (DATA_WIDTH=16, EXT_DIM=4, FRAC_BITS=12).
module tb_dot_product_engine;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     start;
  logic [0:63]              va, vb;
  logic                     done;
  logic signed [15:0]       result;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dot_product_engine #(.DATA_WIDTH(16), .EXT_DIM(4), .FRAC_BITS(12)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .vector_a (va),
    .vector_b (vb),
    .done     (done),
    .result   (result)
  );

  typedef struct {
    logic [0:63] a;
    logic [0:63] b;
    int          exp_t;
    int          exp_r;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:63] pack4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e0), 16'(e1), 16'(e2), 16'(e3)};
  endfunction

  function automatic int model(input logic [0:63] a, input logic [0:63] b);
    longint s = 0;
    for (int i = 0; i < 4; i++)
      s += longint'(shortint'(a[i*16 +: 16])) * longint'(shortint'(b[i*16 +: 16]));
`ifdef DOTP_ROUND_EN
    s += 2048;
`endif
    s = s >>> 12;
    if (s > 32767)       s = 32767;
    else if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  // Raise start with the given operands and count edges until done (bounded).
  task automatic run_req(input logic [0:63] a, input logic [0:63] b, output int edges);
    va = a;
    vb = b;
    start = 1'b1;
    edges = 0;
    while (!done && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic wait_done(inout int edges);
    while (!done && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic release_start(input string name, input int exp);
    start = 1'b0;
    tick();
    check({name, "_done_low"}, int'(done), 0);
    check({name, "_hold"}, int'(result), exp);
  endtask

  initial begin
    int          edges;
    int          exp;
    bit          done_seen;
    logic [0:63] ra, rb;

    tbl[0] = '{pack4(4096, 8192, 12288, 0), pack4(4096, 4096, 4096, 0), 24576, 24576};
    tbl[1] = '{pack4(16384, 16384, 16384, 16384), pack4(16384, 16384, 16384, 16384), 32767, 32767};
    tbl[2] = '{pack4(-16384, -16384, -16384, -16384), pack4(16384, 16384, 16384, 16384), -32768, -32768};
    tbl[3] = '{pack4(1, 0, 0, 0), pack4(2048, 0, 0, 0), 0, 1};
    tbl[4] = '{pack4(-1, 0, 0, 0), pack4(1, 0, 0, 0), -1, 0};
    tbl[5] = '{pack4(-8192, 4096, 6144, 1024), pack4(4096, -2048, 4096, 8192), -2048, -2048};
    tbl[6] = '{pack4(4095, 0, 0, 0), pack4(4095, 0, 0, 0), 4094, 4094};
    tbl[7] = '{pack4(0, 0, 0, 4096), pack4(0, 0, 0, -4096), -4096, -4096};

    rstn  = 1'b0;
    start = 1'b0;
    va    = '0;
    vb    = '0;
    #12;
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("post_reset_done", int'(done), 0);

    for (int k = 0; k < 8; k++) begin
`ifdef DOTP_ROUND_EN
      exp = tbl[k].exp_r;
`else
      exp = tbl[k].exp_t;
`endif
      run_req(tbl[k].a, tbl[k].b, edges);
      check($sformatf("vec%0d_latency", k), edges, 6);
      check($sformatf("vec%0d_result", k), int'(result), exp);
      release_start($sformatf("vec%0d", k), exp);
    end

    // Operands change right after the capture edge; the result must not.
    va = tbl[0].a;
    vb = tbl[0].b;
    start = 1'b1;
    tick();
    va = '0;
    edges = 1;
    wait_done(edges);
    check("stable_latency", edges, 6);
    check("stable_result", int'(result), 24576);
    release_start("stable", 24576);

    // Abort: start drops before the third edge; done must stay low, result untouched.
    va = tbl[1].a;
    vb = tbl[1].b;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) done_seen = 1'b1;
    end
    check("abort_done_never", int'(done_seen), 0);
    check("abort_result", int'(result), 24576);

    // Reset in the middle of MAC, then release it with start already high.
    start = 1'b1;
    tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    check("midreset_done", int'(done), 0);
    check("midreset_result", int'(result), 0);
    @(negedge clk);
    rstn = 1'b1;
    edges = 0;
    wait_done(edges);
    check("rst_release_latency", edges, 6);
    check("rst_release_result", int'(result), 32767);
    release_start("rst_release", 32767);

    run_req(tbl[0].a, tbl[0].b, edges);
    check("rerun_latency", edges, 6);
    check("rerun_result", int'(result), 24576);
    release_start("rerun", 24576);

    // Back-to-back estimation burst: 3x4 requests, one-cycle start-low gaps.
    for (int k = 0; k < 12; k++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      exp = model(ra, rb);
      run_req(ra, rb, edges);
      check($sformatf("b2b%0d_latency", k), edges, 6);
      check($sformatf("b2b%0d_result", k), int'(result), exp);
      release_start($sformatf("b2b%0d", k), exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
